// File: rtl/alu_arbiter_2req.sv
// alu_arbiter_2req: two-port round-robin front end for one shared external
// AND/OR/ADD/SUB ALU. It accepts one request at a time, decodes the function
// code into ALU control lines, registers the ALU result and returns it to the
// requester that issued it.
//
// Handshakes (both sides use strict valid/ready semantics):
//   request : a transfer happens on the rising edge where reqN_valid && reqN_ready.
//             reqN_ready is combinational, high only in IDLE and only for the
//             granted requester; it never depends on a prior ready.
//   response: rspN_valid rises in RESP for the owner only and holds, with
//             rsp_result/rsp_cout/rsp_err stable, until the edge where
//             rspN_valid && rspN_ack. The non-owner's ack is ignored.
module alu_arbiter_2req #(
   parameter int   WIDTH   = 32,
   parameter logic RR_INIT = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_func,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_func,
   output logic             rsp0_valid,
   input  logic             rsp0_ack,
   output logic             rsp1_valid,
   input  logic             rsp1_ack,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_cout,
   output logic             rsp_err,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_op,
   output logic             alu_binvert,
   output logic             alu_cin,
   input  logic [WIDTH-1:0] alu_res,
   input  logic             alu_cout,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic             r_ptr;
   logic             r_owner;
   logic             r_binvert;
   logic             r_err;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;

   logic             w_gnt_any;
   logic             w_gnt_id;
   logic             w_accept;
   logic             w_rsp_done;
   logic             w_owner_ack;
   logic [WIDTH-1:0] w_sel_a;
   logic [WIDTH-1:0] w_sel_b;
   logic [2:0]       w_sel_func;
   logic [1:0]       w_dec_op;
   logic             w_dec_binvert;
   logic             w_dec_err;

   // Grant: a lone valid requester wins; on a tie the pointer decides.
   assign w_gnt_any   = req0_valid | req1_valid;
   assign w_gnt_id    = (req0_valid && req1_valid) ? r_ptr : req1_valid;
   assign w_sel_a     = w_gnt_id ? req1_a    : req0_a;
   assign w_sel_b     = w_gnt_id ? req1_b    : req0_b;
   assign w_sel_func  = w_gnt_id ? req1_func : req0_func;
   assign w_owner_ack = r_owner ? rsp1_ack : rsp0_ack;

   // Decode the granted function code into ALU select, B-invert and error flag.
   always_comb begin
      w_dec_op      = 2'b00;
      w_dec_binvert = 1'b0;
      w_dec_err     = 1'b0;
      case (w_sel_func)
         3'b000:  w_dec_op = 2'b00;
         3'b001:  w_dec_op = 2'b01;
         3'b010:  w_dec_op = 2'b10;
         3'b110: begin
            w_dec_op      = 2'b10;
            w_dec_binvert = 1'b1;
         end
         default: w_dec_err = 1'b1;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // FSM next state, request ready and the accept/response-done strobes.
   always_comb begin
      w_next_state = r_state;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      w_accept     = 1'b0;
      w_rsp_done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_gnt_any) begin
               req0_ready   = ~w_gnt_id;
               req1_ready   = w_gnt_id;
               w_accept     = 1'b1;
               w_next_state = S_EXEC;
            end
         end
         S_EXEC: w_next_state = S_RESP;
         S_RESP: begin
            if (w_owner_ack) begin
               w_rsp_done   = 1'b1;
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Latch operands, decoded controls and owner on accept; they drive the ALU
   // until the next accept, so the ALU inputs stay stable through RESP.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a       <= '0;
         r_b       <= '0;
         r_op      <= 2'b00;
         r_binvert <= 1'b0;
         r_err     <= 1'b0;
         r_owner   <= 1'b0;
      end else if (w_accept) begin
         r_a       <= w_sel_a;
         r_b       <= w_sel_b;
         r_op      <= w_dec_op;
         r_binvert <= w_dec_binvert;
         r_err     <= w_dec_err;
         r_owner   <= w_gnt_id;
      end
   end

   // Capture the ALU output at the end of EXEC; a reserved code returns zeros.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_result <= '0;
         rsp_cout   <= 1'b0;
         rsp_err    <= 1'b0;
      end else if (r_state == S_EXEC) begin
         rsp_result <= r_err ? '0 : alu_res;
         rsp_cout   <= r_err ? 1'b0 : alu_cout;
         rsp_err    <= r_err;
      end
   end

   // Priority pointer passes to the other requester once a response is consumed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           r_ptr <= RR_INIT;
      else if (w_rsp_done) r_ptr <= ~r_owner;
   end

   assign rsp0_valid  = (r_state == S_RESP) && !r_owner;
   assign rsp1_valid  = (r_state == S_RESP) &&  r_owner;
   assign alu_a       = r_a;
   assign alu_b       = r_b;
   assign alu_op      = r_op;
   assign alu_binvert = r_binvert;
   assign alu_cin     = r_binvert;
   assign busy        = (r_state != S_IDLE);
   assign dbg_state   = r_state;

endmodule

// File: doc/alu_arbiter_2req.md
Name: alu_arbiter_2req

Overview:
Shares the single 32-bit AND/OR/ADD/SUB ALU between two requesters, such as a fetch-side address incrementer and the execute stage. It arbitrates round-robin between the two request ports and decodes a 3-bit function code into the ALU control lines. It captures the ALU result in a register and returns it on a per-requester response port with valid/ack handshake. The ALU instance stays external; this block drives its inputs and samples its outputs.

Parameters:
WIDTH, 32, operand/result width; must match the ALU (32).
RR_INIT, 0, requester holding priority after reset (0 or 1).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req0_valid / req1_valid  input  1  request pending.
req0_ready / req1_ready  output  1  request accepted this cycle (valid&&ready).
req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands.
req0_func / req1_func  input  3  000 AND, 001 OR, 010 ADD, 110 SUB; others reserved.
rsp0_valid / rsp1_valid  output  1  response available.
rsp0_ack / rsp1_ack  input  1  requester consumes response.
rsp_result  output  WIDTH  registered result (shared, qualified by rspN_valid).
rsp_cout  output  1  registered ALU carry-out.
rsp_err  output  1  reserved func code was issued.
alu_a, alu_b  output  WIDTH  ALU operands.
alu_op  output  2  ALU select (00 AND, 01 OR, 10 add/sub).
alu_binvert  output  1  ALU B-invert.
alu_cin  output  1  ALU carry-in (equals alu_binvert).
alu_res  input  WIDTH  ALU result (combinational).
alu_cout  input  1  ALU carry-out.
busy  output  1  state != IDLE.

Behaviour:
- Reset, asynchronous: state=IDLE, priority pointer=RR_INIT, operand/control/result registers=0, all rsp*_valid=0, rsp_err=0, busy=0. alu_* outputs=0.
- State machine IDLE -> EXEC -> RESP -> IDLE.
- IDLE: grant goes to the valid requester; if both are valid, to the pointer. reqN_ready=1 combinationally only for the granted requester and only in IDLE. On handshake, latch a, b, func and owner id, then go to EXEC. With no valid request, stay in IDLE and drive all ready signals to 0.
- Decode at latch time:
  - AND: op=00, binvert=0.
  - OR: op=01, binvert=0.
  - ADD: op=10, binvert=0.
  - SUB: op=10, binvert=1.
  - cin=binvert in every case.
  - Reserved code: op=00, binvert=0, err flag set.
- alu_* outputs come straight from the latched registers, so they are stable from EXEC until the next accept.
- EXEC, one cycle: at the clock edge, rsp_result<=alu_res and rsp_cout<=alu_cout. For a reserved code, rsp_result<=0, rsp_cout<=0, rsp_err<=1; otherwise rsp_err<=0. Then go to RESP.
- RESP: rspN_valid=1 for the owner only. Hold result, cout and err stable until rspN_ack=1, then go to IDLE and set the pointer to the other requester. The other requester's ack is ignored. No new request is accepted in RESP.
- Latency: accept at edge T, rsp valid during cycle T+2. Minimum issue interval is 3 cycles (ack in the first RESP cycle).
- Fairness: with both valid continuously, grants alternate 0,1,0,1 regardless of RR_INIT after the first grant.
- A requester dropping valid before ready is legal: no grant, and the pointer is unchanged.
- Arithmetic is modulo 2^WIDTH. SUB cout is 1 when a>=b (unsigned), per the ALU's two's-complement add.
- Reset mid-EXEC or mid-RESP: the operation and pending response are discarded, with no rsp valid after reset. The requester must reissue.

Test Plan:
- req0 AND, a=A5A5A5A5, b=5A5A5A5A, accepted at T -> rsp0_valid at T+2, rsp_result=00000000, rsp_cout=0, alu_op=00.
- req1 ADD with the same operands -> rsp_result=FFFFFFFF, cout=0. req1 SUB -> rsp_result=4B4B4B4B, cout=1, alu_binvert=alu_cin=1.
- Both valid continuously with RR_INIT=0, immediate acks -> grant order req0,req1,req0,req1, with a ready pulse every 3 cycles; never both ready in the same cycle.
- rsp0_ack held low 5 cycles -> rsp0_valid, rsp_result and alu_* stay stable; req1_ready stays 0 throughout. Ack then req1 is accepted the next cycle.
- req0_func=011 -> rsp_err=1, rsp_result=0, cout=0. A following legal OR (A5A5A5A5|5A5A5A5A) -> FFFFFFFF with rsp_err=0.
- reset pulsed during EXEC -> outputs go 0 immediately and no rsp_valid follows; the pointer is back at RR_INIT and a fresh request completes normally.
